vga_fetch: RTL

VGA_FETCH -- requirements
Module: vga_fetch

---
 rtl/vga_fetch.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/vga_fetch.sv
// vga_fetch: 640x480 VGA timing generator fed by a frame-buffer prefetch FIFO.
// Define VGA_FETCH_TESTPAT_EN to add the test_pattern colour-bar input.
module vga_fetch #(
  parameter int CLK_DIV     = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int FRAME_WORDS = 153600
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        fetch_req,
  input  logic        fetch_ack,
  input  logic [35:0] fetch_data,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic [17:0] pixel,
  output logic        underflow
`ifdef VGA_FETCH_TESTPAT_EN
  ,
  input  logic        test_pattern
`endif
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] WAIT1 = 2'd2;
  localparam logic [1:0] WAIT2 = 2'd3;

  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [9:0]    hcount;
  logic [9:0]    vcount;
  logic          active;
  logic          pop;
  logic          do_pop;
  logic          push;
  logic          empty;
  logic          frame_evt;

  logic [35:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [35:0]   head;

  logic [1:0]    state;
  logic [17:0]   words_fetched;
  logic [17:0]   lo_q;

  assign tick      = (div_cnt == DW'(CLK_DIV - 1));
  assign active    = (hcount < 10'd640) && (vcount < 10'd480);
  assign pop       = tick && active && !hcount[0];
  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  assign frame_evt = tick && (hcount == 10'd0) && (vcount == 10'd490);
  assign push      = (state == WAIT2) && !frame_evt;
  assign head      = mem[rd_ptr];
  assign fetch_req = (state == REQ);

`ifdef VGA_FETCH_TESTPAT_EN
  logic [20:0] bar_prod;
  logic [17:0] bar_px;
  assign bar_prod = (21'h3FFFF * {18'd0, hcount[9:7]}) / 21'd7;
  assign bar_px   = bar_prod[17:0];
`endif

  // pixel-tick divider and raster counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      hcount  <= '0;
      vcount  <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      if (hcount == 10'd799) begin
        hcount <= '0;
        vcount <= (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
      end else begin
        hcount <= hcount + 10'd1;
      end
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // fetch FSM: one request in flight, data lands two clks after ack
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      words_fetched <= '0;
    end else if (frame_evt) begin
      state         <= IDLE;
      words_fetched <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (count < CW'(FIFO_DEPTH) &&
              words_fetched < 18'(FRAME_WORDS))
            state <= REQ;
        end
        REQ:   if (fetch_ack) state <= WAIT1;
        WAIT1: state <= WAIT2;
        WAIT2: begin
          state         <= IDLE;
          words_fetched <= words_fetched + 18'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; flushed at frame restart
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (frame_evt) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, push}
                     - {{AW{1'b0}}, do_pop};
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= fetch_data;
  end

  // registered video outputs, updated one clk after each tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_start <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank       <= 1'b1;
      pixel       <= '0;
      lo_q        <= '0;
      underflow   <= 1'b0;
    end else begin
      frame_start <= frame_evt;
      if (pop && empty) underflow <= 1'b1;
      if (tick) begin
        hsync <= !(hcount >= 10'd656 && hcount <= 10'd751);
        vsync <= !(vcount == 10'd490 || vcount == 10'd491);
        blank <= !active;
        if (pop) lo_q <= empty ? 18'd0 : head[17:0];
        if (!active)
          pixel <= '0;
`ifdef VGA_FETCH_TESTPAT_EN
        else if (test_pattern)
          pixel <= bar_px;
`endif
        else if (!hcount[0])
          pixel <= empty ? 18'd0 : head[35:18];
        else
          pixel <= lo_q;
      end
    end
  end

endmodule
